// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out bundle for the 3x3 window generator.
// The master drives the raster stream; the slave (the generator) drives the window.
interface window_gen_3x3_if #(
    parameter int N = 8
);
    logic [N-1:0] pix_in;
    logic         pix_valid;
    logic [N-1:0] sw_pixel_1;
    logic [N-1:0] sw_pixel_2;
    logic [N-1:0] sw_pixel_3;
    logic [N-1:0] sw_pixel_4;
    logic [N-1:0] sw_pixel_5;
    logic [N-1:0] sw_pixel_6;
    logic [N-1:0] sw_pixel_7;
    logic [N-1:0] sw_pixel_8;
    logic [N-1:0] sw_pixel_9;
    logic         win_valid;
    logic         frame_done;

    modport master (
        output pix_in, pix_valid,
        input  sw_pixel_1, sw_pixel_2, sw_pixel_3,
        input  sw_pixel_4, sw_pixel_5, sw_pixel_6,
        input  sw_pixel_7, sw_pixel_8, sw_pixel_9,
        input  win_valid, frame_done
    );

    modport slave (
        input  pix_in, pix_valid,
        output sw_pixel_1, sw_pixel_2, sw_pixel_3,
        output sw_pixel_4, sw_pixel_5, sw_pixel_6,
        output sw_pixel_7, sw_pixel_8, sw_pixel_9,
        output win_valid, frame_done
    );
endinterface

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 sliding-window generator: two line buffers feed the right-hand
// column of a 3x3 register array; a window is flagged once it lies fully inside the image.
module window_gen_3x3 #(
    parameter int N     = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    window_gen_3x3_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [N-1:0]  r_lb1 [IMG_W];
    logic [N-1:0]  r_lb2 [IMG_W];
    logic [N-1:0]  r_win [3][3];
    logic          r_win_valid;
    logic          r_frame_done;

    logic          w_accept;
    logic          w_col_last;
    logic          w_row_last;
    logic [N-1:0]  w_top;
    logic [N-1:0]  w_mid;

    assign w_accept   = bus.pix_valid;
    assign w_col_last = (r_col == CW'(IMG_W - 1));
    assign w_row_last = (r_row == RW'(IMG_H - 1));
    assign w_top      = r_lb2[r_col];
    assign w_mid      = r_lb1[r_col];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Line buffers are plain RAM; rows 0-1 never reach a valid window, so stale data stays hidden.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb2[r_col] <= r_lb1[r_col];
            r_lb1[r_col] <= bus.pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_win_valid  <= w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));
            r_frame_done <= w_accept && w_row_last && w_col_last;
            if (w_accept) begin
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_top;
                r_win[1][2] <= w_mid;
                r_win[2][2] <= bus.pix_in;
            end
        end
    end

    assign bus.sw_pixel_1 = r_win[0][0];
    assign bus.sw_pixel_2 = r_win[0][1];
    assign bus.sw_pixel_3 = r_win[0][2];
    assign bus.sw_pixel_4 = r_win[1][0];
    assign bus.sw_pixel_5 = r_win[1][1];
    assign bus.sw_pixel_6 = r_win[1][2];
    assign bus.sw_pixel_7 = r_win[2][0];
    assign bus.sw_pixel_8 = r_win[2][1];
    assign bus.sw_pixel_9 = r_win[2][2];
    assign bus.win_valid  = r_win_valid;
    assign bus.frame_done = r_frame_done;
endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Streaming 3x3 sliding-window generator that sits directly upstream of the filter stage.
- Accepts one raster-order pixel per cycle: left to right, then top to bottom, frame after frame.
- Uses two line buffers plus a 3x3 register array to present nine window pixels in parallel.
- Feeds the filter's sw_pixel_1..sw_pixel_9 inputs, with a qualifying valid and an end-of-frame pulse.

Parameters:
- N, 8, pixel bit width.
- IMG_W, 8, image width in pixels (>=3).
- IMG_H, 8, image height in lines (>=3).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pix_in  input  N  incoming raster pixel.
- pix_valid  input  1  pix_in is accepted on this rising edge.
- sw_pixel_1..sw_pixel_9  output  N each  window, row-major; sw_pixel_1 = top-left, sw_pixel_5 = centre, sw_pixel_9 = bottom-right.
- win_valid  output  1  window outputs hold a complete in-image window.
- frame_done  output  1  one-cycle pulse; last pixel of the frame has been consumed.

Behaviour:
- Reset (async assert, sync release):
  - col/row counters = 0; window registers = 0; win_valid = 0; frame_done = 0.
  - Line-buffer RAM is not reset; stale contents are never exposed, because output is gated by row>=2.
- Counters:
  - col is 0..IMG_W-1 and row is 0..IMG_H-1, each $clog2 wide.
  - Both advance only on an accepted pixel. col wraps to 0 and increments row.
  - At (IMG_H-1, IMG_W-1) both wrap to 0; the next pixel starts a new frame with no gap required.
- Line buffers (two, depth IMG_W, single address = col), on an accepted pixel:
  - Read top = lb2[col], mid = lb1[col].
  - Write lb2[col] <= lb1[col] and lb1[col] <= pix_in.
  - Read-before-write in the same cycle is required.
- Window shift, on an accepted pixel:
  - Column 0 <= column 1, column 1 <= column 2.
  - Column 2 <= {top, mid, pix_in} as rows 0, 1, 2.
  - Registered outputs: sw_pixel_1/2/3 = row 0 of columns 0/1/2; sw_pixel_4/5/6 = row 1; sw_pixel_7/8/9 = row 2.
- win_valid:
  - Registered. Set to 1 on the edge that accepts pixel (r,c) with r>=2 and c>=2; otherwise set to 0.
  - Latency: one cycle from accepted pixel to window/valid.
  - The window is centred on (r-1, c-1). Output image is (IMG_W-2) x (IMG_H-2); there is no border padding.
- Row wrap: windows spanning column IMG_W-1 and column 0 are suppressed because c<2.
- Stall:
  - pix_valid=0 leaves counters, line buffers and window registers unchanged.
  - win_valid and frame_done are driven 0 during a stall.
  - Each window is reported exactly once.
- frame_done:
  - Registered pulse, asserted the cycle after the pixel at (IMG_H-1, IMG_W-1) is accepted.
  - Coincides with the last win_valid of the frame.
- Reset mid-frame:
  - Counters restart at (0,0). The first valid window again requires two full fresh rows plus 3 pixels.
  - No partial-frame frame_done is issued.
- Throughput: one pixel per cycle sustained; no backpressure input (the consumer must accept every win_valid).

Test Plan:
- IMG_W=4, IMG_H=4, pixel(r,c)=10r+c, continuous pix_valid:
  - First win_valid appears 1 cycle after pixel 22, with window 0,1,2,10,11,12,20,21,22.
  - Exactly 4 win_valid pulses in total.
  - Last window 11,12,13,21,22,23,31,32,33, with frame_done high in that same cycle only.
- Same stream with pix_valid low for 3 cycles after every 2nd pixel -> identical window sequence; win_valid and frame_done never high during a stall; no duplicate windows.
- Two back-to-back 4x4 frames, frame 2 pixel = 100+10r+c:
  - No win_valid during frame 2 rows 0-1.
  - First frame-2 window is 100,101,102,110,111,112,120,121,122.
  - frame_done pulses twice.
- Row-wrap check, IMG_W=5, IMG_H=3:
  - Windows appear only for c=2,3,4 of row 2, 3 windows total.
  - No window mixes column 4 and column 0 data.
- Assert rst_n low mid-frame at pixel (2,1), then restart the frame from (0,0):
  - All outputs are 0 during reset.
  - The first window after restart matches the fresh-frame values; no frame_done for the aborted frame.
- Default IMG_W=8, IMG_H=8 random pixels versus a software reference model -> 36 windows, bit-exact, in raster order.
